regfile_wb_arbiter: RTL and testbench



---
 rtl/rv_pkg.sv | 18 +
 rtl/rr_arbiter.sv | 54 +++++
 rtl/regfile_wb_arbiter.sv | 92 +++++++++
 tb/tb_regfile_wb_arbiter.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// Shared register-file constants and small helpers used by the writeback path.
package rv_pkg;

    localparam int WORD_SIZE  = 32;
    localparam int REG_ADDR_W = 5;
    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

    // Number of set bits in a request vector of up to eight requesters.
    function automatic logic [3:0] count_ones(input logic [7:0] vec);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'b000, vec[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: the search starts just after the last granted requester.
// The pointer moves only when the caller reports that the grant was taken.
module rr_arbiter #(
    parameter int NUM_REQ = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               enable,
    input  logic               advance,
    output logic [NUM_REQ-1:0] grant
);

    localparam int IDX_W = $clog2(NUM_REQ);

    logic [IDX_W-1:0] last_grant_r;
    logic [IDX_W-1:0] grant_idx_s;
    logic [IDX_W-1:0] cand_s;
    logic             found_s;

    // Pick the first valid requester after last_grant, wrapping around.
    always_comb begin
        grant       = {NUM_REQ{1'b0}};
        grant_idx_s = last_grant_r;
        cand_s      = last_grant_r;
        found_s     = 1'b0;
        if (enable) begin
            for (int k = 1; k <= NUM_REQ; k++) begin
                cand_s = IDX_W'((int'(last_grant_r) + k) % NUM_REQ);
                if (!found_s && req[cand_s]) begin
                    grant[cand_s] = 1'b1;
                    grant_idx_s   = cand_s;
                    found_s       = 1'b1;
                end else begin
                    found_s = found_s;
                end
            end
        end else begin
            grant = {NUM_REQ{1'b0}};
        end
    end

    // Pointer register; reset value gives requester 0 first priority.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_grant_r <= IDX_W'(NUM_REQ - 1);
        end else if (advance) begin
            last_grant_r <= grant_idx_s;
        end else begin
            last_grant_r <= last_grant_r;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port among writeback sources. A round-robin
// grant launches the winner into a one-deep registered write stage; writes to
// x0 are accepted but never enabled. A saturating counter records contention.
module regfile_wb_arbiter
    import rv_pkg::*;
#(
    parameter int WORD_SIZE = rv_pkg::WORD_SIZE,
    parameter int NUM_REQ   = 3,
    parameter int CNT_W     = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           stall,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ*REG_ADDR_W-1:0]  req_rd,
    input  logic [NUM_REQ*WORD_SIZE-1:0]   req_data,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic                           wr_en,
    output logic [REG_ADDR_W-1:0]          wr_rd,
    output logic [WORD_SIZE-1:0]           wr_data,
    output logic [CNT_W-1:0]               conflict_cnt
);

    logic [NUM_REQ-1:0]    grant_s;
    logic                  transfer_s;
    logic [REG_ADDR_W-1:0] win_rd_s;
    logic [WORD_SIZE-1:0]  win_data_s;
    logic                  conflict_s;
    logic                  wr_en_r;
    logic [REG_ADDR_W-1:0] wr_rd_r;
    logic [WORD_SIZE-1:0]  wr_data_r;
    logic [CNT_W-1:0]      conflict_cnt_r;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arbiter (
        .clk     (clk),
        .rst     (rst),
        .req     (req_valid),
        .enable  (!stall),
        .advance (transfer_s),
        .grant   (grant_s)
    );

    assign req_ready  = grant_s;
    assign transfer_s = |(grant_s & req_valid);
    assign conflict_s = !stall && (count_ones(8'(req_valid)) >= 4'd2);

    // One-hot AND-OR mux selecting the granted requester's rd and data.
    always_comb begin
        win_rd_s   = REG_ZERO;
        win_data_s = {WORD_SIZE{1'b0}};
        for (int i = 0; i < NUM_REQ; i++) begin
            win_rd_s   = win_rd_s   | (req_rd[i*REG_ADDR_W +: REG_ADDR_W] & {REG_ADDR_W{grant_s[i]}});
            win_data_s = win_data_s | (req_data[i*WORD_SIZE +: WORD_SIZE] & {WORD_SIZE{grant_s[i]}});
        end
    end

    // Write stage: capture the winner; x0 targets load but keep the enable low.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_en_r   <= 1'b0;
            wr_rd_r   <= REG_ZERO;
            wr_data_r <= {WORD_SIZE{1'b0}};
        end else if (transfer_s) begin
            wr_en_r   <= (win_rd_s != REG_ZERO);
            wr_rd_r   <= win_rd_s;
            wr_data_r <= win_data_s;
        end else begin
            wr_en_r   <= 1'b0;
            wr_rd_r   <= wr_rd_r;
            wr_data_r <= wr_data_r;
        end
    end

    // Contention counter, stops at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            conflict_cnt_r <= {CNT_W{1'b0}};
        end else if (conflict_s && !(&conflict_cnt_r)) begin
            conflict_cnt_r <= conflict_cnt_r + CNT_W'(1);
        end else begin
            conflict_cnt_r <= conflict_cnt_r;
        end
    end

    assign wr_en        = wr_en_r;
    assign wr_rd        = wr_rd_r;
    assign wr_data      = wr_data_r;
    assign conflict_cnt = conflict_cnt_r;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: the stimulus side predicts grants,
// write-stage contents and counter values from the round-robin rules and queues
// them; a negedge monitor pops and compares. A second instance uses CNT_W=4.
module tb_regfile_wb_arbiter;

    localparam int N = 3;
    localparam int W = 32;

    logic           clk = 1'b0;
    logic           rst;
    logic           stall;
    logic [N-1:0]   req_valid;
    logic [N*5-1:0] req_rd;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   req_ready;
    logic           wr_en;
    logic [4:0]     wr_rd;
    logic [W-1:0]   wr_data;
    logic [15:0]    conflict_cnt;
    logic [N-1:0]   b_req_ready;
    logic           b_wr_en;
    logic [4:0]     b_wr_rd;
    logic [W-1:0]   b_wr_data;
    logic [3:0]     b_conflict_cnt;

    always #5 clk = ~clk;

    regfile_wb_arbiter #(.WORD_SIZE(W), .NUM_REQ(N), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .stall(stall), .req_valid(req_valid),
        .req_rd(req_rd), .req_data(req_data), .req_ready(req_ready),
        .wr_en(wr_en), .wr_rd(wr_rd), .wr_data(wr_data),
        .conflict_cnt(conflict_cnt)
    );

    regfile_wb_arbiter #(.WORD_SIZE(W), .NUM_REQ(N), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .stall(stall), .req_valid(req_valid),
        .req_rd(req_rd), .req_data(req_data), .req_ready(b_req_ready),
        .wr_en(b_wr_en), .wr_rd(b_wr_rd), .wr_data(b_wr_data),
        .conflict_cnt(b_conflict_cnt)
    );

    typedef struct {
        logic wen;
        int   c16;
        int   c4;
    } post_t;

    typedef struct {
        logic [4:0]   rd;
        logic [W-1:0] d;
    } wr_t;

    // Reference state: pending requests per requester, last winner, counters.
    bit           pend [N];
    logic [4:0]   prd  [N];
    logic [W-1:0] pdata[N];
    int           ptr;
    int           cnt16;
    int           cnt4;

    logic [N-1:0] grant_q[$];
    post_t        post_q[$];
    wr_t          wr_q[$];

    int vectors;
    int miscompares;
    bit mon_en;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive_inputs();
        for (int i = 0; i < N; i++) begin
            req_valid[i]        = pend[i];
            req_rd[i*5 +: 5]    = prd[i];
            req_data[i*W +: W]  = pdata[i];
        end
    endtask

    task automatic post_req(input int i, input logic [4:0] rd, input logic [W-1:0] d);
        if (!pend[i]) begin
            pend[i]  = 1'b1;
            prd[i]   = rd;
            pdata[i] = d;
        end
    endtask

    function automatic post_t reset_post();
        post_t p;
        p.wen = 1'b0;
        p.c16 = 0;
        p.c4  = 0;
        return p;
    endfunction

    // One clock interval, entered and left 1 time unit after a rising edge.
    task automatic step(input logic st);
        int           nvalid;
        int           win;
        logic [N-1:0] g;
        post_t        p;
        wr_t          w;
        nvalid = 0;
        win    = -1;
        g      = '0;
        stall  = st;
        drive_inputs();
        for (int i = 0; i < N; i++) begin
            if (pend[i]) nvalid++;
        end
        if (!st) begin
            for (int k = 1; k <= N; k++) begin
                if (win < 0 && pend[(ptr + k) % N]) win = (ptr + k) % N;
            end
        end
        p.wen = 1'b0;
        if (win >= 0) begin
            g[win]  = 1'b1;
            ptr     = win;
            pend[win] = 1'b0;
            if (prd[win] != 5'd0) begin
                p.wen = 1'b1;
                w.rd  = prd[win];
                w.d   = pdata[win];
                wr_q.push_back(w);
            end
        end
        if (!st && nvalid >= 2) begin
            if (cnt16 < 65535) cnt16++;
            if (cnt4 < 15) cnt4++;
        end
        p.c16 = cnt16;
        p.c4  = cnt4;
        grant_q.push_back(g);
        post_q.push_back(p);
        @(posedge clk);
        #1;
    endtask

    post_t mon_p;
    wr_t   mon_w;

    // Monitor: compare grant, write stage and counters in the middle of each cycle.
    always @(negedge clk) begin
        if (mon_en) begin
            if (grant_q.size() > 0) check("req_ready", 64'(req_ready), 64'(grant_q.pop_front()));
            if (post_q.size() > 0) begin
                mon_p = post_q.pop_front();
                check("wr_en", 64'(wr_en), 64'(mon_p.wen));
                check("conflict_cnt", 64'(conflict_cnt), 64'(mon_p.c16));
                check("conflict_cnt_w4", 64'(b_conflict_cnt), 64'(mon_p.c4));
            end
            if (wr_en) begin
                if (wr_q.size() == 0) begin
                    check("unexpected_write", 64'(wr_en), 64'd0);
                end else begin
                    mon_w = wr_q.pop_front();
                    check("wr_rd", 64'(wr_rd), 64'(mon_w.rd));
                    check("wr_data", 64'(wr_data), 64'(mon_w.d));
                end
            end
        end
    end

    initial begin
        vectors     = 0;
        miscompares = 0;
        mon_en      = 1'b0;
        ptr         = N - 1;
        cnt16       = 0;
        cnt4        = 0;
        for (int i = 0; i < N; i++) begin
            pend[i]  = 1'b0;
            prd[i]   = 5'd0;
            pdata[i] = '0;
        end
        rst   = 1'b0;
        stall = 1'b0;
        drive_inputs();

        // Reset state.
        #12;
        check("rst_wr_en", 64'(wr_en), 64'd0);
        check("rst_wr_rd", 64'(wr_rd), 64'd0);
        check("rst_wr_data", 64'(wr_data), 64'd0);
        check("rst_cnt", 64'(conflict_cnt), 64'd0);
        check("rst_cnt_w4", 64'(b_conflict_cnt), 64'd0);
        check("rst_ready", 64'(req_ready), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        post_q.push_back(reset_post());
        mon_en = 1'b1;

        // Single write from requester 1.
        post_req(1, 5'd5, 32'hDEADBEEF);
        step(1'b0);
        step(1'b0);
        step(1'b0);

        // All requesters continuously valid.
        repeat (6) begin
            for (int i = 0; i < N; i++) post_req(i, 5'($urandom_range(1, 31)), $urandom);
            step(1'b0);
        end
        repeat (3) step(1'b0);

        // Write to x0 is accepted and suppressed.
        post_req(0, 5'd0, 32'h00001234);
        step(1'b0);
        step(1'b0);

        // Stall with requesters 0 and 2 waiting, then release.
        post_req(0, 5'd11, 32'hA5A5_0000);
        post_req(2, 5'd22, 32'h0000_5A5A);
        repeat (3) step(1'b1);
        repeat (3) step(1'b0);

        // Asynchronous reset while a write is in the stage.
        post_req(0, 5'd3, 32'h3333_3333);
        post_req(1, 5'd9, 32'h9999_9999);
        step(1'b0);
        mon_en = 1'b0;
        check("pre_rst_wr_en", 64'(wr_en), 64'd1);
        rst = 1'b0;
        #1;
        check("async_rst_wr_en", 64'(wr_en), 64'd0);
        check("async_rst_wr_rd", 64'(wr_rd), 64'd0);
        check("async_rst_cnt", 64'(conflict_cnt), 64'd0);
        grant_q.delete();
        post_q.delete();
        wr_q.delete();
        ptr   = N - 1;
        cnt16 = 0;
        cnt4  = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        post_q.push_back(reset_post());
        mon_en = 1'b1;
        step(1'b0);
        step(1'b0);

        // Narrow counter saturation.
        repeat (20) begin
            post_req(0, 5'($urandom_range(1, 31)), $urandom);
            post_req(1, 5'($urandom_range(1, 31)), $urandom);
            step(1'b0);
        end
        check("cnt_w4_saturated", 64'(b_conflict_cnt), 64'hF);
        repeat (3) step(1'b0);

        // Randomized traffic with random stalls.
        repeat (400) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 2) != 0) post_req(i, 5'($urandom_range(0, 31)), $urandom);
            end
            step($urandom_range(0, 3) == 0);
        end
        repeat (4) step(1'b0);

        check("drain_writes", 64'(wr_q.size()), 64'd0);
        check("drain_grants", 64'(grant_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
